// File: rtl/output_delta_calc_if.sv
// ---------------------------------------------------------------------------
// output_delta_calc_if
// Bundles the control, activation-buffer read and result signals of the
// output-layer delta stage.
//   start      : one-cycle request to compute a new set of deltas
//   label      : class index of the one-hot target, latched on accepted start
//   rd_en      : activation-buffer read enable
//   rd_addr    : activation-buffer read address
//   rd_data    : activation word, valid one cycle after a sampled rd_en
//   busy       : high while a pass is in progress
//   done       : one-cycle pulse when all deltas are valid
//   delta_flat : delta_i on bits [i*DWIDTH +: DWIDTH]
//   err_sum    : (only with OUTPUT_DELTA_ERR_ACC_EN) sum of |t_i - a_i|
// Modport slave is the delta stage itself; master is whoever drives it.
// ---------------------------------------------------------------------------
interface output_delta_calc_if #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 4,
    parameter int N      = 16
) ();
    logic                   start;
    logic [AWIDTH-1:0]      label;
    logic                   rd_en;
    logic [AWIDTH-1:0]      rd_addr;
    logic [DWIDTH-1:0]      rd_data;
    logic                   busy;
    logic                   done;
    logic [N*DWIDTH-1:0]    delta_flat;
`ifdef OUTPUT_DELTA_ERR_ACC_EN
    logic [DWIDTH+AWIDTH-1:0] err_sum;

    modport slave (
        input  start, label, rd_data,
        output rd_en, rd_addr, busy, done, delta_flat, err_sum
    );

    modport master (
        output start, label, rd_data,
        input  rd_en, rd_addr, busy, done, delta_flat, err_sum
    );
`else
    modport slave (
        input  start, label, rd_data,
        output rd_en, rd_addr, busy, done, delta_flat
    );

    modport master (
        output start, label, rd_data,
        input  rd_en, rd_addr, busy, done, delta_flat
    );
`endif
endinterface

// File: rtl/output_delta_calc.sv
// ---------------------------------------------------------------------------
// output_delta_calc
// Output-layer error stage of the backpropagation datapath. On each accepted
// start it reads the N output activations a_i from the forward-pass buffer
// and computes delta_i = (t_i - a_i) * a_i * (ONE - a_i) in signed fixed
// point, with t_i one-hot on the latched label. Results are held in a
// register bank until the next accepted start.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous reset, active-high
//   bus : output_delta_calc_if.slave (start/label, buffer read, busy/done,
//         delta_flat, optional err_sum)
// Optional feature: define OUTPUT_DELTA_ERR_ACC_EN to add err_sum, the
// accumulated |t_i - a_i| over a pass.
// ---------------------------------------------------------------------------
module output_delta_calc #(
    parameter int DWIDTH = 16,
    parameter int FRAC   = 8,
    parameter int N      = 16,
    parameter int AWIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output_delta_calc_if.slave    bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    // Wide enough that neither product can overflow before saturation.
    localparam int W = 3*DWIDTH + 4;
    localparam logic signed [W-1:0] ONE_W = W'(1 << FRAC);
    localparam logic signed [W-1:0] MAX_W = W'((1 << (DWIDTH-1)) - 1);
    localparam logic signed [W-1:0] MIN_W = -MAX_W - W'(1);
    localparam logic [AWIDTH-1:0]   LAST  = AWIDTH'(N-1);

    logic [1:0]          state_q, state_d;
    logic                rdEn_q, rdEn_d;
    logic [AWIDTH-1:0]   rdAddr_q, rdAddr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [AWIDTH-1:0]   label_q, label_d;
    logic                accept;

    // Read-return tracking: the word on rd_data belongs to slot idx_q
    // whenever slotValid_q is set (one cycle behind the issued address).
    logic                slotValid_q;
    logic [AWIDTH-1:0]   idx_q;

    logic [DWIDTH-1:0]   delta_q [N];

    logic signed [W-1:0] actW, tgtW, errW, omaW, adW, dW, edW, resW, absErrW;
    logic [DWIDTH-1:0]   satRes;

    // Sequencer: issue addresses 0..N-1 back to back, then wait one cycle
    // for the last word to come back before pulsing done.
    always_comb begin
        state_d  = state_q;
        rdEn_d   = rdEn_q;
        rdAddr_d = rdAddr_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        label_d  = label_q;
        accept   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    accept   = 1'b1;
                    state_d  = READ;
                    label_d  = bus.label;
                    busy_d   = 1'b1;
                    rdEn_d   = 1'b1;
                    rdAddr_d = '0;
                end
            end
            READ: begin
                if (rdAddr_q == LAST) begin
                    rdEn_d  = 1'b0;
                    state_d = DRAIN;
                end else begin
                    rdAddr_d = rdAddr_q + 1'b1;
                end
            end
            DRAIN: begin
                state_d = DONE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Delta arithmetic on the returning word. Everything is sign-extended
    // to W bits so both >>> shifts floor toward -inf and saturation sees
    // the true value.
    always_comb begin
        actW    = W'(signed'(bus.rd_data));
        tgtW    = (idx_q == label_q) ? ONE_W : '0;
        errW    = tgtW - actW;
        omaW    = ONE_W - actW;
        adW     = actW * omaW;
        dW      = adW >>> FRAC;
        edW     = errW * dW;
        resW    = edW >>> FRAC;
        absErrW = errW[W-1] ? -errW : errW;
        if (resW > MAX_W) begin
            satRes = MAX_W[DWIDTH-1:0];
        end else if (resW < MIN_W) begin
            satRes = MIN_W[DWIDTH-1:0];
        end else begin
            satRes = resW[DWIDTH-1:0];
        end
    end

    // State, read pipeline and result bank. A slot is only written when its
    // own word returns, so earlier slots of the previous pass stay visible
    // until overwritten.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rdEn_q      <= 1'b0;
            rdAddr_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            label_q     <= '0;
            slotValid_q <= 1'b0;
            idx_q       <= '0;
            for (int i = 0; i < N; i++) begin
                delta_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            rdEn_q      <= rdEn_d;
            rdAddr_q    <= rdAddr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            label_q     <= label_d;
            slotValid_q <= rdEn_q;
            idx_q       <= rdAddr_q;
            if (slotValid_q) begin
                delta_q[idx_q] <= satRes;
            end
        end
    end

`ifdef OUTPUT_DELTA_ERR_ACC_EN
    logic [DWIDTH+AWIDTH-1:0] errSum_q;

    // Running sum of |t_i - a_i|; restarts at zero on each accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            errSum_q <= '0;
        end else if (accept) begin
            errSum_q <= '0;
        end else if (slotValid_q) begin
            errSum_q <= errSum_q + absErrW[DWIDTH+AWIDTH-1:0];
        end
    end

    assign bus.err_sum = errSum_q;
`endif

    // Flatten the result bank onto the output bus.
    always_comb begin
        bus.delta_flat = '0;
        for (int i = 0; i < N; i++) begin
            bus.delta_flat[i*DWIDTH +: DWIDTH] = delta_q[i];
        end
    end

    assign bus.rd_en   = rdEn_q;
    assign bus.rd_addr = rdAddr_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_output_delta_calc.sv
// ---------------------------------------------------------------------------
// tb_output_delta_calc
// Directed bench for output_delta_calc: a table of activation patterns with
// hand-computed deltas, plus sequences for reset mid-pass and start
// re-pulsing. A small memory stands in for the activation buffer.
// ---------------------------------------------------------------------------
module tb_output_delta_calc;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int NN = 16;

    typedef struct {
        logic [3:0]  lbl;
        logic [15:0] fill;
        bit          hasSpec;
        logic [3:0]  specIdx;
        logic [15:0] specVal;
        logic [15:0] expFill;
        logic [15:0] expLabel;
        logic [15:0] expSpec;
        int          expErr;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   testCount = 0;
    int   failCount = 0;
    int   doneCount = 0;
    int   addrLog [$];
    logic [15:0] mem [NN];
    vec_t vecs [6];

    // 10 ns clock.
    always #5 clk = ~clk;

    output_delta_calc_if #(.DWIDTH(DW), .AWIDTH(AW), .N(NN)) bus ();

    output_delta_calc #(.DWIDTH(DW), .FRAC(8), .N(NN), .AWIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Activation buffer model with one-cycle read latency.
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
    end

    // Record issued addresses and count done pulses.
    always @(posedge clk) begin
        if (!rst && bus.rd_en) addrLog.push_back(int'(bus.rd_addr));
        if (!rst && bus.done) doneCount++;
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Runs one pass from start to done. With repulse set, start is pulsed
    // again at cycles 3 and 10 (with a different label) and on the done cycle.
    task automatic runPass(input logic [3:0] lbl, input bit repulse, output int doneEdge);
        addrLog.delete();
        doneEdge = -1;
        @(negedge clk);
        bus.start = 1'b1;
        bus.label = lbl;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checkOutput("busy after start", longint'(bus.busy), 1);
        checkOutput("rd_en after start", longint'(bus.rd_en), 1);
        for (int k = 1; k <= 40; k++) begin
            if (repulse && (k == 3 || k == 10)) begin
                bus.start = 1'b1;
                bus.label = 4'd9;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (bus.done) begin
                doneEdge = k;
                break;
            end
        end
        if (repulse) bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checkOutput("done one cycle", longint'(bus.done), 0);
    endtask

    task automatic checkDeltas(input vec_t v, input string tag);
        logic [15:0] exp;
        for (int i = 0; i < NN; i++) begin
            if (v.hasSpec && i == int'(v.specIdx)) exp = v.expSpec;
            else if (i == int'(v.lbl)) exp = v.expLabel;
            else exp = v.expFill;
            checkOutput($sformatf("%s delta[%0d]", tag, i),
                        longint'(bus.delta_flat[i*DW +: DW]), longint'(exp));
        end
    endtask

    task automatic checkAddrs(input string tag);
        checkOutput({tag, " addr count"}, longint'(addrLog.size()), NN);
        for (int i = 0; i < addrLog.size() && i < NN; i++) begin
            checkOutput($sformatf("%s addr[%0d]", tag, i), longint'(addrLog[i]), i);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        int doneEdge;
        int doneBefore;
        for (int i = 0; i < NN; i++) mem[i] = v.fill;
        if (v.hasSpec) mem[v.specIdx] = v.specVal;
        doneBefore = doneCount;
        runPass(v.lbl, 1'b0, doneEdge);
        checkOutput({tag, " done latency"}, longint'(doneEdge), 17);
        checkOutput({tag, " done pulses"}, longint'(doneCount - doneBefore), 1);
        checkDeltas(v, tag);
        checkAddrs(tag);
`ifdef OUTPUT_DELTA_ERR_ACC_EN
        checkOutput({tag, " err_sum"}, longint'(bus.err_sum), longint'(v.expErr));
`endif
    endtask

    initial begin
        int doneEdge;
        int doneBefore;
        bit sawDone;

        vecs[0] = '{4'd3, 16'd128, 1'b0, 4'd0, 16'h0000, 16'hFFE0, 16'h0020, 16'h0000, 2048};
        vecs[1] = '{4'd0, 16'd0,   1'b0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 256};
        vecs[2] = '{4'd5, 16'd256, 1'b0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3840};
        vecs[3] = '{4'd2, 16'd128, 1'b1, 4'd2, 16'h8000, 16'hFFE0, 16'h0000, 16'h8000, 34944};
        vecs[4] = '{4'd7, 16'd100, 1'b1, 4'd7, 16'h7FFF, 16'hFFE8, 16'h0000, 16'h7FFF, 34011};
        vecs[5] = '{4'd9, 16'd100, 1'b1, 4'd1, 16'hFF00, 16'hFFE8, 16'h0024, 16'hFE00, 1812};

        bus.start = 1'b0;
        bus.label = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset rd_en", longint'(bus.rd_en), 0);
        checkOutput("reset rd_addr", longint'(bus.rd_addr), 0);
        checkOutput("reset busy", longint'(bus.busy), 0);
        checkOutput("reset done", longint'(bus.done), 0);
        checkOutput("reset deltas zero", longint'(bus.delta_flat == '0), 1);
`ifdef OUTPUT_DELTA_ERR_ACC_EN
        checkOutput("reset err_sum", longint'(bus.err_sum), 0);
`endif
        @(negedge clk);
        rst = 1'b0;

        for (int n = 0; n < 6; n++) begin
            applyStimulus(vecs[n], $sformatf("vec%0d", n));
        end

        // Reset in the middle of a pass, after several slots were written.
        for (int i = 0; i < NN; i++) mem[i] = 16'd128;
        doneBefore = doneCount;
        @(negedge clk);
        bus.start = 1'b1;
        bus.label = 4'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midreset rd_en", longint'(bus.rd_en), 0);
        checkOutput("midreset busy", longint'(bus.busy), 0);
        checkOutput("midreset deltas zero", longint'(bus.delta_flat == '0), 1);
        sawDone = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.done) sawDone = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.done) sawDone = 1'b1;
        end
        checkOutput("midreset no done", longint'(sawDone), 0);
        checkOutput("midreset done count", longint'(doneCount - doneBefore), 0);
        applyStimulus(vecs[0], "after reset");

        // Start re-pulsed during the pass and on the done cycle.
        for (int i = 0; i < NN; i++) mem[i] = 16'd128;
        doneBefore = doneCount;
        runPass(4'd3, 1'b1, doneEdge);
        checkOutput("repulse done latency", longint'(doneEdge), 17);
        checkDeltas(vecs[0], "repulse");
        checkAddrs("repulse");
        repeat (5) @(posedge clk);
        #1;
        checkOutput("repulse idle busy", longint'(bus.busy), 0);
        checkOutput("repulse idle rd_en", longint'(bus.rd_en), 0);
        checkOutput("repulse done pulses", longint'(doneCount - doneBefore), 1);
        checkOutput("repulse addr count after idle", longint'(addrLog.size()), NN);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/output_delta_calc.md
Name: output_delta_calc

Overview:
- Output-layer error stage of the backpropagation datapath. Sits directly upstream of the hidden-layer weight/delta calculation stage.
- On each start, it streams the N output-neuron activations from the forward-pass output buffer. For each neuron i it computes delta_i = (t_i - a_i) * a_i * (ONE - a_i).
- The N results are held in a register bank that drives that stage's delta1..deltaN inputs.
- Target vector is one-hot and derived from a class label latched at start.

Parameters:
- DWIDTH, 16: data word width, signed fixed point.
- FRAC, 8: fractional bits; ONE = 1<<FRAC (256).
- N, 16: number of output neurons.
- AWIDTH, 4: activation-buffer address width (2^AWIDTH >= N).

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: asynchronous reset, active-high.
- start, in, 1: one-cycle request; sampled only in IDLE.
- label, in, AWIDTH: target class index; latched on accepted start.
- rd_en, out, 1: activation-buffer read enable.
- rd_addr, out, AWIDTH: activation-buffer read address.
- rd_data, in, DWIDTH: activation word; valid the cycle after rd_en is sampled (1-cycle read latency).
- busy, out, 1: high from accepted start until done.
- done, out, 1: one-cycle pulse when all N deltas are valid.
- delta_flat, out, N*DWIDTH: delta_i on bits [i*DWIDTH +: DWIDTH]; held until next accepted start.

Behaviour:
- Reset (async, any state): state=IDLE; rd_en=0, rd_addr=0, busy=0, done=0; all delta registers 0; latched label 0.
- FSM states:
  - IDLE: start=1 at edge E0 -> READ; label latched; busy=1; rd_addr=0; rd_en=1 from E0.
  - READ: rd_addr increments each edge while rd_en=1. After addr N-1 is issued, rd_en drops and state goes to DRAIN.
  - DRAIN: waits for the last returning word, registers it -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Pipeline timing:
  - addr k is issued during the cycle after edge E_k.
  - Its data is present after E_{k+1}.
  - delta_k is registered at E_{k+2}.
  - delta_{N-1} is registered at E_{N+1}; done is high in the cycle following E_{N+1}.
  - start to done = N+1 edges.
- Arithmetic:
  - t_i = ONE if i == latched label, else 0.
  - e = t_i - a_i, computed in DWIDTH+1 bits.
  - d = (a_i * (ONE - a_i)) >>> FRAC.
  - delta = (e * d) >>> FRAC.
  - Arithmetic right shift, truncation toward -inf.
  - Final result saturated to the signed DWIDTH range; no wrap.
- Delta registers are overwritten only at their own slot. Untouched slots keep their old value until written in the current pass.
- start while busy: ignored, no restart, label not re-latched.
- start asserted in the same cycle as done: ignored; a new start is accepted from the following IDLE cycle.
- label >= N: all targets are 0, so every delta uses t=0.
- Reset mid-pass: immediate return to IDLE; deltas cleared; no done pulse.

Optional Feature:
- Macro: OUTPUT_DELTA_ERR_ACC_EN.
- Defined:
  - Adds output err_sum [DWIDTH+AWIDTH-1:0], unsigned.
  - Accumulates |t_i - a_i| over the pass, cleared on accepted start.
  - Final value is valid when done is high and held until the next start.
  - Reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset mid-READ (assert rst at cycle 5 of a pass) -> rd_en=0, busy=0, all delta_flat=0, no done; a subsequent start runs a normal full pass.
- label=3, all rd_data=128 (0.5) -> delta_3=32, all other deltas = -32 (16'hFFE0); done exactly 17 edges after the start edge.
- label=0, rd_data = 0 for all i -> all deltas 0; with OUTPUT_DELTA_ERR_ACC_EN defined, err_sum=256.
- label=5, rd_data[5]=256 and others 256 -> delta_5=0 and other deltas=0 (derivative term 0); saturation not triggered.
- start re-pulsed at cycles 3 and 10 of a pass, plus start coincident with done -> single done per accepted start; label unchanged; rd_addr sequence 0..15 exactly once.
- rd_data=16'h8000 (-128.0) for neuron 2, label=2 -> result clamps to 16'h7FFF or 16'h8000 per sign; no wrap.
